pipelined_chunk_adder: RTL and testbench

Parametrised, pipelined add/subtract unit for WIDTH-bit operands, split into CHUNK-bit ripple slices with one register stage per slice. The carry between slices is registered, so clock frequency is set by a single CHUNK-bit ripple rather than the full operand width. A valid/ready handshake on both sides lets it sit between the operand-fetch and writeback stages of the lab datapath. Throughput is one operation per cycle; latency is WIDTH/CHUNK cycles.

---
 rtl/pipelined_chunk_adder_pkg.sv | 19 +
 rtl/adder_chunk.sv | 29 ++
 rtl/pipelined_chunk_adder.sv | 149 ++++++++++++++
 tb/tb_pipelined_chunk_adder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_chunk_adder_pkg.sv
// Shared definitions for the chunked pipelined adder:
// op encodings, stage-count derivation and the geometry check.
package pipelined_chunk_adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   function automatic int calc_stages(int width, int chunk);
      return width / chunk;
   endfunction

   // Legal geometry: 1 <= chunk <= width and width a multiple of chunk.
   function automatic bit chunk_ok(int width, int chunk);
      return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder slice.
// Ports: a, b, cin in; s, cout (carry out of MSB), c_msb (carry into MSB) out.
module adder_chunk
   import pipelined_chunk_adder_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   always_comb begin
      logic c;
      c     = cin;
      s     = '0;
      c_msb = 1'b0;
      for (int i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) c_msb = c;
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined add/subtract, one register stage per CHUNK-bit slice.
// Ports: clk, rst_n; in_valid/in_ready, a, b, cin, op in;
// out_valid/out_ready, s, cout, ovf out.
module pipelined_chunk_adder
   import pipelined_chunk_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = calc_stages(WIDTH, CHUNK);

   if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("pipelined_chunk_adder: WIDTH must be a multiple of CHUNK");
   end

   logic                         stall;
   logic                         adv;
   logic [WIDTH-1:0]             b_eff;
   logic                         c0;
   logic [STAGES-1:0]            vld;
   logic [STAGES-1:0][CHUNK-1:0] sum_w;
   logic [STAGES-1:0]            co_w;
   logic [STAGES-1:0][CHUNK-1:0] sq;
   logic [STAGES-1:0]            cq;
   logic [STAGES-1:0][CHUNK-1:0] res;
   logic                         cm_last;
   logic                         ovf_q;

   assign stall     = out_valid & ~out_ready;
   assign adv       = ~stall;
   assign in_ready  = adv;
   assign out_valid = vld[STAGES-1];

   // Subtract is a + ~b + 1; cin only matters for add.
   assign b_eff = (op_e'(op) == OP_SUB) ? ~b : b;
   assign c0    = (op_e'(op) == OP_SUB) ? 1'b1 : cin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld   <= '0;
         sq    <= '0;
         cq    <= '0;
         ovf_q <= 1'b0;
      end else if (adv) begin
         vld   <= (vld << 1) | STAGES'(in_valid);
         sq    <= sum_w;
         cq    <= co_w;
         ovf_q <= cm_last ^ co_w[STAGES-1];
      end
   end

   for (genvar j = 0; j < STAGES; j++) begin : g_sl
      localparam int DSK = STAGES - 1 - j;

      logic [CHUNK-1:0] op_a;
      logic [CHUNK-1:0] op_b;
      logic             ci;

      // Slice 0 works straight off the inputs; slice j sees its
      // operands through j skew registers and the carry of slice j-1.
      if (j == 0) begin : g_head
         assign op_a = a[CHUNK-1:0];
         assign op_b = b_eff[CHUNK-1:0];
         assign ci   = c0;
      end else begin : g_skew
         logic [CHUNK-1:0] a_sk [j];
         logic [CHUNK-1:0] b_sk [j];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_sk <= '{default: '0};
               b_sk <= '{default: '0};
            end else if (adv) begin
               a_sk[0] <= a[j*CHUNK +: CHUNK];
               b_sk[0] <= b_eff[j*CHUNK +: CHUNK];
               for (int k = 1; k < j; k++) begin
                  a_sk[k] <= a_sk[k-1];
                  b_sk[k] <= b_sk[k-1];
               end
            end
         end

         assign op_a = a_sk[j-1];
         assign op_b = b_sk[j-1];
         assign ci   = cq[j-1];
      end

      if (j == STAGES - 1) begin : g_last
         adder_chunk #(.CHUNK(CHUNK)) u_add (
            .a    (op_a),
            .b    (op_b),
            .cin  (ci),
            .s    (sum_w[j]),
            .cout (co_w[j]),
            .c_msb(cm_last)
         );
      end else begin : g_mid
         logic cm_unused;
         adder_chunk #(.CHUNK(CHUNK)) u_add (
            .a    (op_a),
            .b    (op_b),
            .cin  (ci),
            .s    (sum_w[j]),
            .cout (co_w[j]),
            .c_msb(cm_unused)
         );
      end

      // Early slices wait out the remaining stages so all emerge aligned.
      if (DSK == 0) begin : g_nodsk
         assign res[j] = sq[j];
      end else begin : g_dsk
         logic [CHUNK-1:0] d_q [DSK];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               d_q <= '{default: '0};
            end else if (adv) begin
               d_q[0] <= sq[j];
               for (int k = 1; k < DSK; k++) begin
                  d_q[k] <= d_q[k-1];
               end
            end
         end

         assign res[j] = d_q[DSK-1];
      end
   end

   assign s    = res;
   assign cout = cq[STAGES-1];
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Self-checking bench for pipelined_chunk_adder (16/4, 32/8, 8/8).
// Random and directed operands checked against an arithmetic model.
module tb_pipelined_chunk_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv1, iv2, iv3, ordy, op, cin;
   logic [31:0] a, b;
   logic        ir1, ir2, ir3, ov1, ov2, ov3;
   logic        co1, co2, co3, of1, of2, of3;
   logic [15:0] s1;
   logic [31:0] s2;
   logic [7:0]  s3;

   int total = 0;
   int bad   = 0;

   logic [33:0] q1[$];
   logic [33:0] q2[$];
   logic [33:0] q3[$];

   always #5 clk = ~clk;

   pipelined_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
      .a(a[15:0]), .b(b[15:0]), .cin(cin), .op(op),
      .out_valid(ov1), .out_ready(ordy), .s(s1), .cout(co1), .ovf(of1)
   );

   pipelined_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
      .a(a), .b(b), .cin(cin), .op(op),
      .out_valid(ov2), .out_ready(ordy), .s(s2), .cout(co2), .ovf(of2)
   );

   pipelined_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .op(op),
      .out_valid(ov3), .out_ready(ordy), .s(s3), .cout(co3), .ovf(of3)
   );

   // Returns {ovf, cout, sum[31:0]} for a w-bit operation.
   function automatic logic [33:0] model(int w, logic [31:0] x,
                                         logic [31:0] y, logic ci,
                                         logic o);
      logic [63:0] mask, xa, be, sum, sv, t;
      logic        c, v, sa, sb, ss;
      mask = (64'd1 << w) - 64'd1;
      xa   = {32'd0, x} & mask;
      be   = (o ? ~{32'd0, y} : {32'd0, y}) & mask;
      sum  = xa + be + {63'd0, (o | ci)};
      sv   = sum & mask;
      t    = sum >> w;
      c    = t[0];
      t    = xa >> (w - 1);
      sa   = t[0];
      t    = be >> (w - 1);
      sb   = t[0];
      t    = sv >> (w - 1);
      ss   = t[0];
      v    = (sa == sb) && (ss != sa);
      return {v, c, sv[31:0]};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      iv1 = 0; iv2 = 0; iv3 = 0;
      ordy = 1; op = 0; cin = 0; a = 0; b = 0;
      repeat (3) @(negedge clk);
      total++;
      if ({ov1, ov2, ov3} !== 3'b000) begin
         bad++;
         $display("FAIL reset_valid got=%b want=000", {ov1, ov2, ov3});
      end
      total++;
      if ({of1, co1, s1} !== 18'd0) begin
         bad++;
         $display("FAIL reset_out got=%h want=0", {of1, co1, s1});
      end
      rst_n = 1'b1;
      #1;
      total++;
      if ({ir1, ir2, ir3} !== 3'b111) begin
         bad++;
         $display("FAIL reset_ready got=%b want=111", {ir1, ir2, ir3});
      end
   endtask

   task automatic test_directed();
      logic [15:0] av [3] = '{16'hFFFF, 16'h8000, 16'h7FFF};
      logic        opv[3] = '{1'b0, 1'b1, 1'b0};
      logic [15:0] es [3] = '{16'h0000, 16'h7FFF, 16'h8000};
      logic        ec [3] = '{1'b1, 1'b1, 1'b0};
      logic        eo [3] = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = {16'd0, av[i]}; b = 32'd1;
         op = opv[i]; cin = 1'b0; iv1 = 1; ordy = 1;
         for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            iv1 = 0;
            total++;
            if (ov1 !== (k == 4)) begin
               bad++;
               $display("FAIL dir%0d_latency edge=%0d got=%b want=%b",
                        i, k, ov1, (k == 4));
            end
         end
         total++;
         if ({of1, co1, s1} !== {eo[i], ec[i], es[i]}) begin
            bad++;
            $display("FAIL dir%0d_result got=%h want=%h", i,
                     {of1, co1, s1}, {eo[i], ec[i], es[i]});
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [33:0] e;
      int sent = 0;
      int g1 = 0, g2 = 0, g3 = 0;
      int f1 = -1, f2 = -1, f3 = -1;
      int l1 = 0, l2 = 0, l3 = 0;
      q1.delete(); q2.delete(); q3.delete();
      ordy = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ov1) begin
            total++;
            if (q1.size() == 0) begin
               bad++;
               $display("FAIL b2b16_extra got=%h want=none", s1);
            end else begin
               e = q1.pop_front();
               if ({of1, co1, s1} !== {e[33], e[32], e[15:0]}) begin
                  bad++;
                  $display("FAIL b2b16_data got=%h want=%h",
                           {of1, co1, s1}, {e[33], e[32], e[15:0]});
               end
            end
            if (f1 < 0) f1 = c;
            l1 = c; g1++;
         end
         if (ov2) begin
            total++;
            if (q2.size() == 0) begin
               bad++;
               $display("FAIL b2b32_extra got=%h want=none", s2);
            end else begin
               e = q2.pop_front();
               if ({of2, co2, s2} !== e) begin
                  bad++;
                  $display("FAIL b2b32_data got=%h want=%h",
                           {of2, co2, s2}, e);
               end
            end
            if (f2 < 0) f2 = c;
            l2 = c; g2++;
         end
         if (ov3) begin
            total++;
            if (q3.size() == 0) begin
               bad++;
               $display("FAIL b2b8_extra got=%h want=none", s3);
            end else begin
               e = q3.pop_front();
               if ({of3, co3, s3} !== {e[33], e[32], e[7:0]}) begin
                  bad++;
                  $display("FAIL b2b8_data got=%h want=%h",
                           {of3, co3, s3}, {e[33], e[32], e[7:0]});
               end
            end
            if (f3 < 0) f3 = c;
            l3 = c; g3++;
         end
         a = $urandom; b = $urandom;
         op = 1'($urandom); cin = 1'($urandom);
         iv1 = (sent < 8); iv2 = iv1; iv3 = iv1;
         #1;
         if (iv1 && ir1) q1.push_back(model(16, a, b, cin, op));
         if (iv2 && ir2) q2.push_back(model(32, a, b, cin, op));
         if (iv3 && ir3) q3.push_back(model(8, a, b, cin, op));
         if (iv1) sent++;
      end
      iv1 = 0; iv2 = 0; iv3 = 0;
      total++;
      if (g1 != 8 || l1 - f1 != 7) begin
         bad++;
         $display("FAIL b2b16_stream got=%0d span=%0d want=8 span=7",
                  g1, l1 - f1);
      end
      total++;
      if (g2 != 8 || l2 - f2 != 7) begin
         bad++;
         $display("FAIL b2b32_stream got=%0d span=%0d want=8 span=7",
                  g2, l2 - f2);
      end
      total++;
      if (g3 != 8 || l3 - f3 != 7) begin
         bad++;
         $display("FAIL b2b8_stream got=%0d span=%0d want=8 span=7",
                  g3, l3 - f3);
      end
   endtask

   task automatic test_stall();
      logic [33:0] e;
      int g = 0;
      q1.delete();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         ordy = !(c >= 4 && c < 9);
         a = $urandom; b = $urandom;
         op = 1'($urandom); cin = 1'($urandom);
         iv1 = (c < 9);
         #1;
         if (ov1) begin
            total++;
            if (q1.size() == 0) begin
               bad++;
               $display("FAIL stall_extra got=%h want=none", s1);
            end else begin
               e = q1[0];
               if ({of1, co1, s1} !== {e[33], e[32], e[15:0]}) begin
                  bad++;
                  $display("FAIL stall_data c=%0d got=%h want=%h", c,
                           {of1, co1, s1}, {e[33], e[32], e[15:0]});
               end
               if (ordy) e = q1.pop_front();
            end
            if (ordy) g++;
         end
         if (!ordy) begin
            total++;
            if (ir1 !== 1'b0 || ov1 !== 1'b1) begin
               bad++;
               $display("FAIL stall_hold c=%0d got=%b%b want=01",
                        c, ir1, ov1);
            end
         end
         if (iv1 && ir1) q1.push_back(model(16, a, b, cin, op));
      end
      iv1 = 0;
      total++;
      if (g != 4 || q1.size() != 0) begin
         bad++;
         $display("FAIL stall_count got=%0d left=%0d want=4 left=0",
                  g, q1.size());
      end
   endtask

   task automatic test_reset_mid();
      ordy = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         a = $urandom; b = $urandom;
         op = 1'($urandom); cin = 1'($urandom);
         iv1 = 1;
      end
      @(negedge clk);
      iv1 = 0;
      total++;
      if (ov1 !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_pre got=%b want=1", ov1);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({ov1, of1, co1, s1} !== 19'd0) begin
         bad++;
         $display("FAIL rstmid_async got=%h want=0", {ov1, of1, co1, s1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         total++;
         if (ov1 !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_stale c=%0d got=%b want=0", c, ov1);
         end
      end
      a = 32'h1234; b = 32'h1111; op = 0; cin = 0; iv1 = 1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         iv1 = 0;
      end
      total++;
      if ({ov1, of1, co1, s1} !== {1'b1, 1'b0, 1'b0, 16'h2345}) begin
         bad++;
         $display("FAIL rstmid_next got=%h want=%h",
                  {ov1, of1, co1, s1}, {1'b1, 1'b0, 1'b0, 16'h2345});
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
